// File: rtl/p405s_icu_fill_seq.sv
// I-cache line-fill sequencer: captures a miss address, requests the line from the PLB,
// and steers critical-word-first wrapped beats into the array, forwarding the critical word.
module p405s_icu_fill_seq #(
   parameter int WORDS_PER_LINE = 8,
   parameter int IDX_W          = 3
) (
   input  logic             CB,
   input  logic             resetN,
   input  logic             missReq,
   input  logic [0:31]      missAddr,
   output logic             missAck,
   output logic             plbReq,
   output logic [0:31]      plbAddr,
   input  logic             plbAddrAck,
   input  logic             plbRdDAck,
   input  logic [0:31]      plbRdData,
   input  logic             plbRdErr,
   input  logic             abort,
   output logic             arrWrEn,
   output logic [0:IDX_W-1] arrWrIdx,
   output logic [0:31]      arrWrData,
   output logic             critValid,
   output logic [0:31]      critData,
   output logic             fillBusy,
   output logic             fillDone,
   output logic             fillErr
);

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] beat_cnt;
   logic             abort_flag;
   logic             err_flag;

   logic             beat_v;
   logic             last_beat;
   logic             abort_eff;
   logic             err_eff;
   logic             wr_ok;
   logic [IDX_W-1:0] crit_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             unused_addr_lsb;

   // Byte offset within the word is dropped when the fill address is captured.
   assign unused_addr_lsb = ^missAddr[30:31];

   assign crit_idx  = plbAddr[30-IDX_W:29];
   assign wr_idx    = crit_idx + beat_cnt;
   assign beat_v    = (state == DATA) && plbRdDAck;
   assign last_beat = beat_v && (beat_cnt == IDX_W'(WORDS_PER_LINE - 1));
   // A same-cycle abort or error already suppresses the beat it arrives with.
   assign abort_eff = abort_flag || abort;
   assign err_eff   = err_flag || (plbRdDAck && plbRdErr);
   assign wr_ok     = beat_v && !abort_eff && !err_eff;

   always_ff @(posedge CB or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (missReq) state_nxt = REQ;
         REQ: begin
            if (plbAddrAck)  state_nxt = DATA;
            else if (abort)  state_nxt = IDLE;
         end
         DATA:    if (last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      missAck  = missReq && (state == IDLE);
      fillBusy = (state != IDLE);
      critData = arrWrData;
   end

   always_ff @(posedge CB or negedge resetN) begin
      if (!resetN) begin
         plbReq     <= 1'b0;
         plbAddr    <= '0;
         beat_cnt   <= '0;
         abort_flag <= 1'b0;
         err_flag   <= 1'b0;
         arrWrEn    <= 1'b0;
         arrWrIdx   <= '0;
         arrWrData  <= '0;
         critValid  <= 1'b0;
         fillDone   <= 1'b0;
         fillErr    <= 1'b0;
      end else begin
         plbReq    <= (state_nxt == REQ);
         arrWrEn   <= wr_ok;
         critValid <= wr_ok && (beat_cnt == '0);
         fillDone  <= last_beat && !abort_eff && !err_eff;
         fillErr   <= last_beat && err_eff && !abort_eff;

         if (missAck) plbAddr <= {missAddr[0:29], 2'b00};

         if (wr_ok) begin
            arrWrIdx  <= wr_idx;
            arrWrData <= plbRdData;
         end

         if (state != DATA)  beat_cnt <= '0;
         else if (beat_v)    beat_cnt <= beat_cnt + 1'b1;

         // Once the bus has accepted, an abort only masks writes and the completion pulse.
         if (state == REQ) begin
            abort_flag <= abort && plbAddrAck;
            err_flag   <= 1'b0;
         end else if (state == DATA) begin
            if (last_beat) begin
               abort_flag <= 1'b0;
               err_flag   <= 1'b0;
            end else begin
               if (abort)               abort_flag <= 1'b1;
               if (beat_v && plbRdErr)  err_flag   <= 1'b1;
            end
         end else begin
            abort_flag <= 1'b0;
            err_flag   <= 1'b0;
         end
      end
   end

endmodule
